cae_sequencer: RTL and testbench

Host-side job sequencer sitting directly upstream of the external access controller of the path-search accelerator and driving its memory-mapped port as a bus master. It accepts a job (source, destination) and a streamed obstacle bitmap, and writes the obstacles, destination and source in the required order; the source write launches the search. It then polls the done flag and walks the parent memory from destination back to source, streaming the resulting path out.

---
 rtl/cae_sequencer_pkg.sv | 25 ++
 rtl/cae_av_reader.sv | 49 ++++
 rtl/cae_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_cae_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cae_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the CAE job sequencer.
// Bus address map of the accelerator's memory-mapped port.
package cae_sequencer_pkg;

    localparam int BASE_FONTE     = 0;
    localparam int BASE_DESTINO   = 1;
    localparam int BASE_GMA       = 2;
    localparam int BASE_OBSTACULO = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OBS_WAIT,
        S_OBS_WR,
        S_WR_DEST,
        S_WR_FONTE,
        S_POLL,
        S_WALK_RD,
        S_EMIT
    } state_t;

    function automatic int obs_words(input int nodes);
        return (nodes + 31) / 32;
    endfunction

endpackage

// File: rtl/cae_av_reader.sv
// Single outstanding bus read: strobes once, holds the address and
// pulses done when read data is valid READ_LATENCY cycles later.
module cae_av_reader #(
    parameter int AV_ADDR_WIDTH = 32,
    parameter int AV_DATA_WIDTH = 32,
    parameter int READ_LATENCY  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [AV_ADDR_WIDTH-1:0] addr,
    output logic                     read,
    output logic [AV_ADDR_WIDTH-1:0] bus_addr,
    input  logic [AV_DATA_WIDTH-1:0] rdata,
    output logic                     done,
    output logic [AV_DATA_WIDTH-1:0] data,
    output logic                     busy
);

    localparam int CW = $clog2(READ_LATENCY + 1);

    logic [CW-1:0]            cnt;
    logic [AV_ADDR_WIDTH-1:0] addr_q;

    assign read     = start && !busy;
    assign done     = busy && (cnt == CW'(READ_LATENCY));
    assign bus_addr = busy ? addr_q : addr;
    assign data     = rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            addr_q <= '0;
        end else if (read) begin
            busy   <= 1'b1;
            cnt    <= CW'(1);
            addr_q <= addr;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cae_sequencer.sv
// Host-side job sequencer: loads obstacles, destination and source into
// the accelerator, polls for completion and streams the parent-walk path.
module cae_sequencer
    import cae_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH    = 6,
    parameter int AV_DATA_WIDTH = 32,
    parameter int AV_ADDR_WIDTH = 32,
    parameter int READ_LATENCY  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDR_WIDTH-1:0]    cmd_fonte,
    input  logic [ADDR_WIDTH-1:0]    cmd_destino,
    input  logic                     obs_valid,
    output logic                     obs_ready,
    input  logic [31:0]              obs_data,
    output logic [AV_ADDR_WIDTH-1:0] av_addr,
    output logic [AV_DATA_WIDTH-1:0] av_wdata,
    output logic                     av_write,
    output logic                     av_read,
    input  logic [AV_DATA_WIDTH-1:0] av_rdata,
    output logic                     path_valid,
    input  logic                     path_ready,
    output logic [ADDR_WIDTH-1:0]    path_node,
    output logic                     path_last,
    output logic                     busy,
    output logic                     erro
);

    localparam logic [ADDR_WIDTH-1:0] LAST_NODE = '1;

    state_t state, state_d;

    logic [ADDR_WIDTH-1:0] fonte;
    logic [ADDR_WIDTH-1:0] destino;
    logic [ADDR_WIDTH-1:0] node;
    logic [4:0]            bit_idx;
    logic [31:0]           word;
    logic [ADDR_WIDTH-1:0] cur;
    logic [ADDR_WIDTH-1:0] steps;
    logic                  last;

    logic                     rd_start;
    logic [AV_ADDR_WIDTH-1:0] rd_addr_in;
    logic                     rd_read;
    logic [AV_ADDR_WIDTH-1:0] rd_bus_addr;
    logic                     rd_done;
    logic [AV_DATA_WIDTH-1:0] rd_data;
    logic                     rd_busy;
    logic                     unused_rd;

    assign unused_rd = ^{rd_data, rd_busy};

    // The walk also stops after NUM_NODES beats so a parent loop cannot hang us
    assign last = (cur == fonte) || (steps == LAST_NODE);

    assign rd_start   = !rst && ((state == S_POLL) || (state == S_WALK_RD));
    assign rd_addr_in = (state == S_WALK_RD)
                      ? AV_ADDR_WIDTH'(BASE_GMA) + AV_ADDR_WIDTH'(cur)
                      : AV_ADDR_WIDTH'(BASE_FONTE);

    cae_av_reader #(
        .AV_ADDR_WIDTH(AV_ADDR_WIDTH),
        .AV_DATA_WIDTH(AV_DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_reader (
        .clk     (clk),
        .rst     (rst),
        .start   (rd_start),
        .addr    (rd_addr_in),
        .read    (rd_read),
        .bus_addr(rd_bus_addr),
        .rdata   (av_rdata),
        .done    (rd_done),
        .data    (rd_data),
        .busy    (rd_busy)
    );

    always_comb begin
        state_d    = state;
        cmd_ready  = 1'b0;
        obs_ready  = 1'b0;
        av_addr    = '0;
        av_wdata   = '0;
        av_write   = 1'b0;
        av_read    = 1'b0;
        path_valid = 1'b0;
        path_node  = '0;
        path_last  = 1'b0;
        busy       = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = S_OBS_WAIT;
            end
            S_OBS_WAIT: begin
                obs_ready = 1'b1;
                if (obs_valid) state_d = S_OBS_WR;
            end
            S_OBS_WR: begin
                av_write = 1'b1;
                av_addr  = AV_ADDR_WIDTH'(BASE_OBSTACULO) + AV_ADDR_WIDTH'(node);
                av_wdata = AV_DATA_WIDTH'(word[bit_idx]);
                if (node == LAST_NODE) state_d = S_WR_DEST;
                else if (bit_idx == 5'd31) state_d = S_OBS_WAIT;
            end
            S_WR_DEST: begin
                av_write = 1'b1;
                av_addr  = AV_ADDR_WIDTH'(BASE_DESTINO);
                av_wdata = AV_DATA_WIDTH'(destino);
                state_d  = S_WR_FONTE;
            end
            S_WR_FONTE: begin
                av_write = 1'b1;
                av_addr  = AV_ADDR_WIDTH'(BASE_FONTE);
                av_wdata = AV_DATA_WIDTH'(fonte);
                state_d  = S_POLL;
            end
            S_POLL: begin
                av_read = rd_read;
                av_addr = rd_bus_addr;
                if (rd_done && rd_data[0]) state_d = S_EMIT;
            end
            S_WALK_RD: begin
                av_read = rd_read;
                av_addr = rd_bus_addr;
                if (rd_done) state_d = S_EMIT;
            end
            S_EMIT: begin
                path_valid = 1'b1;
                path_node  = cur;
                path_last  = last;
                if (path_ready) state_d = last ? S_IDLE : S_WALK_RD;
            end
            default: state_d = S_IDLE;
        endcase
        // Outputs are forced quiet while reset is held
        if (rst) begin
            cmd_ready  = 1'b0;
            obs_ready  = 1'b0;
            av_addr    = '0;
            av_wdata   = '0;
            av_write   = 1'b0;
            av_read    = 1'b0;
            path_valid = 1'b0;
            path_node  = '0;
            path_last  = 1'b0;
            busy       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            fonte   <= '0;
            destino <= '0;
            node    <= '0;
            bit_idx <= '0;
            word    <= '0;
            cur     <= '0;
            steps   <= '0;
            erro    <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        fonte   <= cmd_fonte;
                        destino <= cmd_destino;
                        erro    <= 1'b0;
                        node    <= '0;
                        bit_idx <= '0;
                    end
                end
                S_OBS_WAIT: begin
                    if (obs_valid) word <= obs_data;
                end
                S_OBS_WR: begin
                    node    <= node + ADDR_WIDTH'(1);
                    bit_idx <= bit_idx + 5'd1;
                end
                S_POLL: begin
                    if (rd_done && rd_data[0]) begin
                        cur   <= destino;
                        steps <= '0;
                    end
                end
                S_WALK_RD: begin
                    if (rd_done) begin
                        cur   <= rd_data[ADDR_WIDTH-1:0];
                        steps <= steps + ADDR_WIDTH'(1);
                    end
                end
                S_EMIT: begin
                    if (path_ready && last && (cur != fonte)) erro <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cae_sequencer.sv
// Directed bench for cae_sequencer with an accelerator bus model and
// scoreboards for bus writes and path beats.
module tb_cae_sequencer;
    import cae_sequencer_pkg::*;

    localparam int AW = 6;
    localparam int NN = 64;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [AW-1:0] node;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_fonte;
    logic [AW-1:0] cmd_destino;
    logic          obs_valid;
    logic          obs_ready;
    logic [31:0]   obs_data;
    logic [31:0]   av_addr;
    logic [31:0]   av_wdata;
    logic          av_write;
    logic          av_read;
    logic [31:0]   av_rdata = '0;
    logic          path_valid;
    logic          path_ready = 1'b1;
    logic [AW-1:0] path_node;
    logic          path_last;
    logic          busy;
    logic          erro;

    int vectors     = 0;
    int miscompares = 0;

    wr_t   exp_wr[$];
    beat_t exp_path[$];

    logic [AW-1:0] par[NN];
    int            done_after = 0;
    int            poll_cnt   = 0;
    logic          rd_pend    = 1'b0;
    logic [31:0]   rd_next;

    int            beats_seen = 0;
    logic          stall_en   = 1'b0;
    int            stall_cnt  = 0;
    logic          hold_vld   = 1'b0;
    logic [AW-1:0] hold_node;
    logic          hold_last;

    always #5 clk = ~clk;

    cae_sequencer #(
        .ADDR_WIDTH   (AW),
        .AV_DATA_WIDTH(32),
        .AV_ADDR_WIDTH(32),
        .READ_LATENCY (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_fonte  (cmd_fonte),
        .cmd_destino(cmd_destino),
        .obs_valid  (obs_valid),
        .obs_ready  (obs_ready),
        .obs_data   (obs_data),
        .av_addr    (av_addr),
        .av_wdata   (av_wdata),
        .av_write   (av_write),
        .av_read    (av_read),
        .av_rdata   (av_rdata),
        .path_valid (path_valid),
        .path_ready (path_ready),
        .path_node  (path_node),
        .path_last  (path_last),
        .busy       (busy),
        .erro       (erro)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Accelerator model: read captured mid-cycle, data valid one cycle later
    always @(negedge clk) begin
        if (!rst && av_write && av_addr == 32'd0) poll_cnt = 0;
        if (!rst && av_read) begin
            if (av_addr == 32'd0) begin
                rd_next = ($urandom() << 1) | ((poll_cnt >= done_after) ? 1 : 0);
                poll_cnt++;
            end else begin
                rd_next = ($urandom() << AW) | 32'(par[int'(av_addr) - 2]);
            end
            rd_pend = 1'b1;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rd_pend) begin
            av_rdata = rd_next;
            rd_pend  = 1'b0;
        end else begin
            av_rdata = $urandom();
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (stall_en && beats_seen == 3 && stall_cnt < 10) begin
            path_ready = 1'b0;
            stall_cnt++;
        end else begin
            path_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        wr_t   e;
        beat_t b;
        if (rst) begin
            hold_vld = 1'b0;
        end else begin
            if (av_write) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", av_addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", av_addr, e.addr);
                    chk("wr_data", av_wdata, e.data);
                end
            end
            if (path_valid) chk("bus_quiet_emit", {30'd0, av_read, av_write}, 32'd0);
            if (hold_vld) begin
                chk("hold_valid", {31'd0, path_valid}, 32'd1);
                chk("hold_node", 32'(path_node), 32'(hold_node));
                chk("hold_last", {31'd0, path_last}, {31'd0, hold_last});
            end
            if (path_valid && path_ready) begin
                beats_seen++;
                if (exp_path.size() == 0) begin
                    chk("beat_unexpected", 32'(path_node), 32'hFFFF_FFFF);
                end else begin
                    b = exp_path.pop_front();
                    chk("path_node", 32'(path_node), 32'(b.node));
                    chk("path_last", {31'd0, path_last}, {31'd0, b.last});
                end
            end
            hold_vld  = path_valid && !path_ready;
            hold_node = path_node;
            hold_last = path_last;
        end
    end

    task automatic run_job(input logic [AW-1:0] f, input logic [AW-1:0] d,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input int gap, input int polls, input bit abort);
        logic [31:0]   wv[2];
        logic [AW-1:0] n;
        int            st;
        int            t;
        wv[0]      = w0;
        wv[1]      = w1;
        done_after = polls;
        beats_seen = 0;
        stall_cnt  = 0;
        n  = d;
        st = 0;
        forever begin
            exp_path.push_back('{node: n, last: (n == f) || (st == NN - 1)});
            if ((n == f) || (st == NN - 1)) break;
            n = par[n];
            st++;
        end
        cmd_fonte   = f;
        cmd_destino = d;
        cmd_valid   = 1'b1;
        t = 0;
        while (!cmd_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("erro_clr", {31'd0, erro}, 32'd0);
        for (int w = 0; w < obs_words(NN); w++) begin
            for (int k = 0; k < 32; k++) begin
                if (32 * w + k < NN)
                    exp_wr.push_back('{addr: 32'(BASE_OBSTACULO + 32 * w + k),
                                       data: {31'd0, wv[w][k]}});
            end
            repeat (gap) @(posedge clk);
            #1;
            obs_data  = wv[w];
            obs_valid = 1'b1;
            t = 0;
            while (!obs_ready && t < 200) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk("obs_accept", {31'd0, obs_ready}, 32'd1);
            @(posedge clk);
            #1;
            obs_valid = 1'b0;
        end
        exp_wr.push_back('{addr: 32'(BASE_DESTINO), data: 32'(d)});
        exp_wr.push_back('{addr: 32'(BASE_FONTE), data: 32'(f)});
        t = 0;
        if (abort) begin
            while (!(exp_wr.size() == 0 && av_read) && t < 500) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk("poll_seen", {31'd0, av_read}, 32'd1);
        end else begin
            while ((exp_path.size() != 0 || !cmd_ready) && t < 5000) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk("job_done", 32'(exp_path.size()), 32'd0);
            chk("wr_drain", 32'(exp_wr.size()), 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_fonte   = '0;
        cmd_destino = '0;
        obs_valid   = 1'b0;
        obs_data    = '0;
        for (int i = 0; i < NN; i++) par[i] = (i == 0) ? '0 : AW'(i - 1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", {24'd0, cmd_ready, obs_ready, av_write, av_read,
                          path_valid, path_last, busy, erro}, 32'd0);
        chk("rst_addr", av_addr, 32'd0);
        chk("rst_wdata", av_wdata, 32'd0);
        chk("rst_node", 32'(path_node), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Empty map, chain 9..0, with a 10-cycle path_ready stall
        stall_en = 1'b1;
        run_job(6'd0, 6'd9, 32'd0, 32'd0, 0, 20, 1'b0);
        stall_en = 1'b0;
        chk("t1_erro", {31'd0, erro}, 32'd0);
        chk("t1_stall", 32'(stall_cnt), 32'd10);

        // Sparse obstacles with obs_valid gaps
        run_job(6'd0, 6'd3, 32'h0000_0005, 32'h8000_0000, 3, 3, 1'b0);
        chk("t2_erro", {31'd0, erro}, 32'd0);

        // Source equals destination
        run_job(6'd17, 6'd17, 32'h1234_5678, 32'd0, 0, 2, 1'b0);
        chk("t3_erro", {31'd0, erro}, 32'd0);

        // Parent loop 5<->6 never reaches source
        par[5] = 6'd6;
        par[6] = 6'd5;
        run_job(6'd0, 6'd5, 32'd0, 32'hFFFF_FFFF, 1, 1, 1'b0);
        chk("t4_erro", {31'd0, erro}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("t4_erro_sticky", {31'd0, erro}, 32'd1);
        par[5] = 6'd4;
        par[6] = 6'd5;

        // Reset while polling
        run_job(6'd0, 6'd2, 32'd0, 32'd0, 0, 1000, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_flags", {24'd0, cmd_ready, obs_ready, av_write, av_read,
                            path_valid, path_last, busy, erro}, 32'd0);
        chk("abort_addr", av_addr, 32'd0);
        exp_path.delete();
        exp_wr.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);

        // Recovery job after abort
        run_job(6'd1, 6'd4, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 0, 2, 1'b0);
        chk("t6_erro", {31'd0, erro}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
